// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous RAM port between three single-word requesters.
// Define ARB_LOCK_EN to enable the per-requester bus lock used for atomic read-modify-write.
module mem_port_arbiter #(
   parameter int AW = 7,
   parameter int DW = 9
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [2:0]      REQ,
   input  logic [2:0]      WE,
   input  logic [3*AW-1:0] ADDR,
   input  logic [3*DW-1:0] WDATA,
   input  logic [2:0]      LOCK,
   output logic [2:0]      GNT,
   output logic [2:0]      RVALID,
   output logic [DW-1:0]   RDATA,
   output logic [1:0]      OWNER,
   output logic            BUSY,
   output logic            MEM_EN,
   output logic            MEM_W,
   output logic [AW-1:0]   MEM_ADDR,
   output logic [DW-1:0]   MEM_WDATA,
   input  logic [DW-1:0]   MEM_RDATA
);

   localparam logic [1:0] ST_ARB = 2'd0;
   localparam logic [1:0] ST_ACC = 2'd1;
   localparam logic [1:0] ST_RD  = 2'd2;

   logic [1:0]    state;
   logic [1:0]    last;
   logic [1:0]    owner;
   logic          we_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;

   logic [2:0]    last_mask;
   logic [2:0]    elig;
   logic [1:0]    cand1;
   logic [1:0]    cand2;
   logic [1:0]    win;
   logic          win_valid;
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;

   assign last_mask = 3'b001 << last;

`ifdef ARB_LOCK_EN
   logic locked;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         locked <= 1'b0;
      end else if (state == ST_ACC) begin
         if (LOCK[last]) locked <= 1'b1;
      end else if (state == ST_ARB && !LOCK[last]) begin
         locked <= 1'b0;
      end
   end
`else
   logic lock_unused;
   assign lock_unused = ^LOCK;
`endif

   // Search order LAST+1, LAST+2, LAST (mod 3): the previous winner ranks last.
   always_comb begin
      cand1 = (last == 2'd2) ? 2'd0 : last + 2'd1;
      cand2 = (cand1 == 2'd2) ? 2'd0 : cand1 + 2'd1;
      elig  = REQ;
`ifdef ARB_LOCK_EN
      if (locked && LOCK[last]) elig = REQ & last_mask;
`endif
      win_valid = 1'b1;
      if (elig[cand1])      win = cand1;
      else if (elig[cand2]) win = cand2;
      else if (elig[last])  win = last;
      else begin
         win       = last;
         win_valid = 1'b0;
      end
   end

   always_comb begin
      case (win)
         2'd0: begin
            sel_we    = WE[0];
            sel_addr  = ADDR[0*AW +: AW];
            sel_wdata = WDATA[0*DW +: DW];
         end
         2'd1: begin
            sel_we    = WE[1];
            sel_addr  = ADDR[1*AW +: AW];
            sel_wdata = WDATA[1*DW +: DW];
         end
         default: begin
            sel_we    = WE[2];
            sel_addr  = ADDR[2*AW +: AW];
            sel_wdata = WDATA[2*DW +: DW];
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state   <= ST_ARB;
         last    <= 2'd2;
         owner   <= 2'd0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         case (state)
            ST_ARB: begin
               if (win_valid) begin
                  state   <= ST_ACC;
                  last    <= win;
                  owner   <= win;
                  we_q    <= sel_we;
                  addr_q  <= sel_addr;
                  wdata_q <= sel_wdata;
               end
            end
            ST_ACC:  state <= we_q ? ST_ARB : ST_RD;
            ST_RD:   state <= ST_ARB;
            default: state <= ST_ARB;
         endcase
      end
   end

   // Strobes decode straight from state so an async reset clears them at once.
   assign BUSY      = (state == ST_ACC) || (state == ST_RD);
   assign MEM_EN    = (state == ST_ACC);
   assign MEM_W     = MEM_EN & we_q;
   assign MEM_ADDR  = addr_q;
   assign MEM_WDATA = wdata_q;
   assign GNT       = MEM_EN ? last_mask : '0;
   assign RVALID    = (state == ST_RD) ? last_mask : '0;
   assign RDATA     = MEM_RDATA;
   assign OWNER     = owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural synchronous RAM on the memory port.
module tb_mem_port_arbiter;

   typedef struct packed {
      logic       w;
      logic [6:0] addr;
      logic [8:0] wdata;
      logic [8:0] rdata;
   } acc_t;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [2:0]  REQ = '0;
   logic [2:0]  WE = '0;
   logic [20:0] ADDR = '0;
   logic [26:0] WDATA = '0;
   logic [2:0]  LOCK = '0;
   logic [2:0]  GNT;
   logic [2:0]  RVALID;
   logic [8:0]  RDATA;
   logic [1:0]  OWNER;
   logic        BUSY;
   logic        MEM_EN;
   logic        MEM_W;
   logic [6:0]  MEM_ADDR;
   logic [8:0]  MEM_WDATA;
   logic [8:0]  MEM_RDATA = '0;

   mem_port_arbiter #(.AW(7), .DW(9)) dut (
      .CLK(CLK), .RST(RST), .REQ(REQ), .WE(WE), .ADDR(ADDR), .WDATA(WDATA), .LOCK(LOCK),
      .GNT(GNT), .RVALID(RVALID), .RDATA(RDATA), .OWNER(OWNER), .BUSY(BUSY),
      .MEM_EN(MEM_EN), .MEM_W(MEM_W), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
      .MEM_RDATA(MEM_RDATA)
   );

   always #5 CLK = ~CLK;

   logic [8:0] ram [128];
   logic       pre_en = 1'b0;
   logic [6:0] pre_addr = '0;
   logic [8:0] pre_data = '0;

   always @(posedge CLK) begin
      if (pre_en) ram[pre_addr] <= pre_data;
      else if (MEM_EN && MEM_W) ram[MEM_ADDR] <= MEM_WDATA;
      if (MEM_EN && !MEM_W) MEM_RDATA <= ram[MEM_ADDR];
   end

   int   n_checks = 0;
   int   n_errors = 0;
   acc_t q0[$];
   acc_t q1[$];
   acc_t q2[$];
   int   exp_order[$];
   logic spacing_on = 1'b0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic push_exp(input int id, input acc_t e);
      case (id)
         0: q0.push_back(e);
         1: q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   // Monitor: every grant pops the owner's expected access; reads expect RVALID the next cycle.
   int         cyc = 0;
   int         last_gnt_cyc = -1;
   logic       rd_due = 1'b0;
   logic [1:0] rd_id = '0;
   logic [8:0] rd_data = '0;

   always @(negedge CLK) begin
      int   id;
      int   qsz;
      acc_t e;
      cyc++;
      if (!spacing_on) last_gnt_cyc = -1;
      if (!RST) begin
         rd_due = 1'b0;
      end else begin
         if (rd_due) begin
            check("rvalid", RVALID, 3'b001 << rd_id);
            check("rdata", RDATA, rd_data);
            check("busy_rd", BUSY, 1);
            rd_due = 1'b0;
         end else if (RVALID != 3'b000) begin
            check("rvalid_unexpected", RVALID, 0);
         end
         if (GNT != 3'b000) begin
            check("gnt_onehot", $countones(GNT), 1);
            id = GNT[0] ? 0 : (GNT[1] ? 1 : 2);
            if (exp_order.size() > 0) check("grant_order", id, exp_order.pop_front());
            qsz = (id == 0) ? q0.size() : ((id == 1) ? q1.size() : q2.size());
            if (qsz == 0) begin
               check("gnt_unexpected", GNT, 0);
            end else begin
               case (id)
                  0: e = q0.pop_front();
                  1: e = q1.pop_front();
                  default: e = q2.pop_front();
               endcase
               check("mem_en", MEM_EN, 1);
               check("mem_w", MEM_W, e.w);
               check("mem_addr", MEM_ADDR, e.addr);
               if (e.w) check("mem_wdata", MEM_WDATA, e.wdata);
               check("owner", OWNER, id);
               check("busy_acc", BUSY, 1);
               if (!e.w) begin
                  rd_due  = 1'b1;
                  rd_id   = 2'(id);
                  rd_data = e.rdata;
               end
            end
            if (spacing_on && last_gnt_cyc >= 0) check("gnt_spacing", cyc - last_gnt_cyc, 2);
            last_gnt_cyc = cyc;
         end else if (MEM_EN) begin
            check("mem_en_without_gnt", MEM_EN, 0);
         end
      end
   end

   task automatic do_req(input int id, input logic w, input logic [6:0] a, input logic [8:0] d,
                         input logic lk, input logic [8:0] rd);
      acc_t e;
      logic got;
      e.w = w; e.addr = a; e.wdata = d; e.rdata = rd;
      push_exp(id, e);
      REQ[id] = 1'b1;
      WE[id] = w;
      ADDR[id*7 +: 7] = a;
      WDATA[id*9 +: 9] = d;
      LOCK[id] = lk;
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge CLK);
         if (GNT[id]) got = 1'b1;
      end
      if (!got) check("gnt_timeout", GNT, 3'b001 << id);
      @(posedge CLK); #1;
      REQ[id] = 1'b0;
      LOCK[id] = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic got;

      // Reset state
      repeat (2) @(negedge CLK);
      check("rst_gnt", GNT, 0);
      check("rst_rvalid", RVALID, 0);
      check("rst_mem_en", MEM_EN, 0);
      check("rst_mem_w", MEM_W, 0);
      check("rst_mem_addr", MEM_ADDR, 0);
      check("rst_mem_wdata", MEM_WDATA, 0);
      check("rst_owner", OWNER, 0);
      check("rst_busy", BUSY, 0);
      @(posedge CLK); #1;
      RST = 1'b1;

      // Idle
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         check("idle_mem_en", MEM_EN, 0);
         check("idle_gnt", GNT, 0);
         check("idle_rvalid", RVALID, 0);
         check("idle_busy", BUSY, 0);
      end

      // Single read of a preloaded word
      @(posedge CLK); #1;
      pre_en = 1'b1; pre_addr = 7'h10; pre_data = 9'h0F0;
      @(posedge CLK); #1;
      pre_en = 1'b0;
      do_req(0, 1'b0, 7'h10, 9'h000, 1'b0, 9'h0F0);

      // Single write
      do_req(1, 1'b1, 7'h05, 9'h1A3, 1'b0, 9'h000);
      check("ram5", ram[5], 9'h1A3);

      // Requester 2 locked read then write, racing requester 0
`ifdef ARB_LOCK_EN
      exp_order.push_back(2); exp_order.push_back(2); exp_order.push_back(0);
`else
      exp_order.push_back(2); exp_order.push_back(0); exp_order.push_back(2);
`endif
      fork
         begin
            do_req(2, 1'b0, 7'h05, 9'h000, 1'b1, 9'h1A3);
            do_req(2, 1'b1, 7'h06, 9'h1FF, 1'b1, 9'h000);
         end
         do_req(0, 1'b1, 7'h30, 9'h055, 1'b0, 9'h000);
      join
      check("ram6", ram[6], 9'h1FF);
      check("ram30", ram[7'h30], 9'h055);

      // Contention: all requesters writing back-to-back from reset
      RST = 1'b0;
      for (int r = 0; r < 2; r++) begin
         exp_order.push_back(0); exp_order.push_back(1); exp_order.push_back(2);
      end
      spacing_on = 1'b1;
      fork
         begin #3; RST = 1'b1; end
         for (int it = 0; it < 2; it++) do_req(0, 1'b1, 7'(8'h20 + it), 9'(9'h040 + it + 1), 1'b0, 9'h000);
         for (int it = 0; it < 2; it++) do_req(1, 1'b1, 7'(8'h24 + it), 9'(9'h080 + it + 1), 1'b0, 9'h000);
         for (int it = 0; it < 2; it++) do_req(2, 1'b1, 7'(8'h28 + it), 9'(9'h0C0 + it + 1), 1'b0, 9'h000);
      join
      spacing_on = 1'b0;
      check("ram21", ram[7'h21], 9'h042);
      check("ram29", ram[7'h29], 9'h0C2);

      // Reset asserted during the access cycle of a read
      @(posedge CLK); #1;
      begin
         acc_t e;
         e.w = 1'b0; e.addr = 7'h10; e.wdata = 9'h000; e.rdata = 9'h0F0;
         push_exp(0, e);
      end
      REQ[0] = 1'b1; WE[0] = 1'b0; ADDR[6:0] = 7'h10;
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge CLK);
         if (GNT[0]) got = 1'b1;
      end
      if (!got) check("midrd_gnt_timeout", GNT, 3'b001);
      #1 RST = 1'b0;
      #1;
      check("midrd_gnt", GNT, 0);
      check("midrd_rvalid", RVALID, 0);
      check("midrd_mem_en", MEM_EN, 0);
      check("midrd_mem_w", MEM_W, 0);
      check("midrd_mem_addr", MEM_ADDR, 0);
      check("midrd_mem_wdata", MEM_WDATA, 0);
      check("midrd_busy", BUSY, 0);
      check("midrd_owner", OWNER, 0);
      REQ = '0;
      repeat (2) @(posedge CLK);
      #1;
      exp_order.push_back(0); exp_order.push_back(1); exp_order.push_back(2);
      fork
         begin #3; RST = 1'b1; end
         do_req(0, 1'b1, 7'h40, 9'h111, 1'b0, 9'h000);
         do_req(1, 1'b1, 7'h41, 9'h122, 1'b0, 9'h000);
         do_req(2, 1'b1, 7'h42, 9'h133, 1'b0, 9'h000);
      join
      repeat (4) @(negedge CLK);
      check("q0_left", q0.size(), 0);
      check("q1_left", q1.size(), 0);
      check("q2_left", q2.size(), 0);
      check("order_left", exp_order.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
